// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage.
// Turns the EX/MEM register contents into a data-memory request. It
// replicates store data across byte lanes, extracts and extends load data,
// and freezes the front of the pipeline while memory is slow to
// acknowledge. A wait counter bounds every access: an access with no ack
// after 255 stalled WAIT cycles is abandoned and flagged as a bus error in
// MEM/WB.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic [31:0] alures_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  DMType_in,
    input  logic [1:0]  WDSel_in,
    input  logic        MemWrite_in,
    input  logic        load_in,
    input  logic        RegWrite_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] PC_out,
    output logic [31:0] alures_out,
    output logic [31:0] memdata_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rd_out,
    output logic [1:0]  WDSel_out,
    output logic        RegWrite_out,
    output logic        misalign_out,
    output logic        buserr_out
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;

    logic        is_store;
    logic        is_load;
    logic        is_valid;
    logic        is_half;
    logic        is_byte;
    logic        is_word;
    logic        misaligned;
    logic        issue;
    logic        timeout;
    logic        completes;
    logic [3:0]  be_raw;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;

    // A store takes priority when both load and store are flagged.
    assign is_store = MemWrite_in;
    assign is_load  = load_in & ~MemWrite_in;
    assign is_valid = is_store | is_load;

    // Access size from DMType; the unused codes fall back to word.
    assign is_half = (DMType_in == 3'b001) || (DMType_in == 3'b010);
    assign is_byte = (DMType_in == 3'b011) || (DMType_in == 3'b100);
    assign is_word = ~is_half & ~is_byte;

    assign misaligned = is_valid &&
                        ((is_word && (alures_in[1:0] != 2'b00)) ||
                         (is_half && alures_in[0]));
    assign issue      = is_valid && !misaligned;

    // Abort on the WAIT cycle in which the counter has hit 255 with no ack.
    // An ack arriving in that same cycle still completes the access.
    assign timeout = (state == S_WAIT) && (wait_cnt == 8'hFF) && !dmem_ack;

    // Upstream registers are frozen during WAIT, so the request fields stay
    // stable while they are derived combinationally from the inputs.
    assign dmem_req   = !rst && (((state == S_IDLE) && issue) || (state == S_WAIT));
    assign dmem_we    = dmem_req && is_store;
    assign dmem_addr  = {alures_in[31:2], 2'b00};
    assign mem_stall  = dmem_req && !dmem_ack && !timeout;
    assign completes  = dmem_req && dmem_ack;
    assign dmem_be    = dmem_req ? be_raw : 4'b0000;

    // Byte enables and lane-replicated write data for the access size.
    always_comb begin
        be_raw     = 4'b1111;
        dmem_wdata = rs2_data_in;
        if (is_half) begin
            be_raw     = alures_in[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{rs2_data_in[15:0]}};
        end else if (is_byte) begin
            be_raw     = 4'b0001 << alures_in[1:0];
            dmem_wdata = {4{rs2_data_in[7:0]}};
        end
    end

    // Pick the addressed halfword/byte out of the read word and extend it.
    always_comb begin
        half_sel = alures_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (alures_in[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        case (DMType_in)
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = {16'h0000, half_sel};
            3'b011:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // Handshake FSM: IDLE issues, WAIT holds the request and counts cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue && !dmem_ack) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'h00;
                    end
                end
                default: begin
                    if (dmem_ack || timeout) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h01;
                    end
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_out       <= 32'h0;
            alures_out   <= 32'h0;
            memdata_out  <= 32'h0;
            imm_out      <= 32'h0;
            rd_out       <= 5'h0;
            WDSel_out    <= 2'h0;
            RegWrite_out <= 1'b0;
            misalign_out <= 1'b0;
            buserr_out   <= 1'b0;
        end else if (mem_stall) begin
            PC_out       <= 32'h0;
            alures_out   <= 32'h0;
            memdata_out  <= 32'h0;
            imm_out      <= 32'h0;
            rd_out       <= 5'h0;
            WDSel_out    <= 2'h0;
            RegWrite_out <= 1'b0;
            misalign_out <= 1'b0;
            buserr_out   <= 1'b0;
        end else begin
            PC_out       <= PC_in;
            alures_out   <= alures_in;
            memdata_out  <= (is_load && completes) ? load_data : 32'h0;
            imm_out      <= imm_in;
            rd_out       <= rd_in;
            WDSel_out    <= WDSel_in;
            RegWrite_out <= RegWrite_in && !misaligned && !timeout;
            misalign_out <= misaligned;
            buserr_out   <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Directed scenarios plus randomized accesses, all checked against a
// behavioural model written with plain arithmetic on sizes and byte offsets.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_in, alures_in, rs2_data_in, imm_in;
    logic [4:0]  rd_in;
    logic [2:0]  DMType_in;
    logic [1:0]  WDSel_in;
    logic        MemWrite_in, load_in, RegWrite_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] PC_out, alures_out, memdata_out, imm_out;
    logic [4:0]  rd_out;
    logic [1:0]  WDSel_out;
    logic        RegWrite_out, misalign_out, buserr_out;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .PC_in(PC_in), .alures_in(alures_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
        .rd_in(rd_in), .DMType_in(DMType_in), .WDSel_in(WDSel_in),
        .MemWrite_in(MemWrite_in), .load_in(load_in), .RegWrite_in(RegWrite_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .PC_out(PC_out), .alures_out(alures_out), .memdata_out(memdata_out), .imm_out(imm_out),
        .rd_out(rd_out), .WDSel_out(WDSel_out), .RegWrite_out(RegWrite_out),
        .misalign_out(misalign_out), .buserr_out(buserr_out)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Access size in bytes implied by DMType.
    function automatic int unsigned m_size(input logic [2:0] dmt);
        if (dmt == 3'd1 || dmt == 3'd2) return 2;
        if (dmt == 3'd3 || dmt == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] dmt, input logic [31:0] addr);
        int unsigned sz;
        sz = m_size(dmt);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] dmt, input logic [31:0] rs2);
        int unsigned sz;
        sz = m_size(dmt);
        if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] dmt, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned sz, off, val;
        sz  = m_size(dmt);
        off = addr % 4;
        if (sz == 4) return rdata;
        val = (rdata >> (8 * off)) & ((1 << (8 * sz)) - 1);
        if ((dmt == 3'd1 || dmt == 3'd3) && val >= (1 << (8 * sz - 1)))
            val = val - (1 << (8 * sz));
        return val;
    endfunction

    task automatic drive_instr(input logic [31:0] pc, alu, rs2, imm, input logic [4:0] rd,
                               input logic [2:0] dmt, input logic [1:0] wds,
                               input logic mw, ld, rw);
        PC_in = pc; alures_in = alu; rs2_data_in = rs2; imm_in = imm;
        rd_in = rd; DMType_in = dmt; WDSel_in = wds;
        MemWrite_in = mw; load_in = ld; RegWrite_in = rw;
    endtask

    // One instruction through the stage; ack arrives after ack_delay WAIT cycles.
    // Entered and left at 1 ns after a rising edge.
    task automatic apply_access(input string name, input logic [31:0] pc, alu, rs2, imm,
                                input logic [4:0] rd, input logic [2:0] dmt, input logic [1:0] wds,
                                input logic mw, ld, rw, input logic [31:0] rdata,
                                input int ack_delay);
        logic valid, mis, issue, is_ld;
        logic [31:0] exp_mem;
        valid = mw | ld;
        is_ld = ld & ~mw;
        mis   = valid && ((alu % m_size(dmt)) != 0);
        issue = valid && !mis;
        exp_mem = (is_ld && issue) ? m_load(dmt, alu, rdata) : 32'h0;
        drive_instr(pc, alu, rs2, imm, rd, dmt, wds, mw, ld, rw);
        dmem_rdata = rdata;
        dmem_ack   = (ack_delay == 0);
        #2;
        checks++;
        if (dmem_req !== issue) begin
            errors++; $display("[TB] FAIL %s req: got %b want %b", name, dmem_req, issue);
        end
        checks++;
        if (mem_stall !== (issue && ack_delay != 0)) begin
            errors++; $display("[TB] FAIL %s stall: got %b want %b", name, mem_stall, issue && ack_delay != 0);
        end
        if (issue) begin
            checks++;
            if (dmem_addr !== (alu & ~32'h3) || dmem_we !== mw) begin
                errors++; $display("[TB] FAIL %s addr/we: got %h/%b want %h/%b", name, dmem_addr, dmem_we, alu & ~32'h3, mw);
            end
            if (mw) begin
                checks++;
                if (dmem_be !== m_be(dmt, alu) || dmem_wdata !== m_wdata(dmt, rs2)) begin
                    errors++; $display("[TB] FAIL %s be/wdata: got %b/%h want %b/%h", name, dmem_be, dmem_wdata, m_be(dmt, alu), m_wdata(dmt, rs2));
                end
            end
        end
        @(posedge clk); #1;
        if (issue && ack_delay != 0) begin
            for (int k = 1; k <= ack_delay; k++) begin
                checks++;
                if ({PC_out, alures_out, memdata_out, imm_out, rd_out, WDSel_out,
                     RegWrite_out, misalign_out, buserr_out} !== '0) begin
                    errors++; $display("[TB] FAIL %s bubble: got pc=%h rw=%b want all zero", name, PC_out, RegWrite_out);
                end
                dmem_ack = (k == ack_delay);
                #2;
                checks++;
                if (dmem_req !== 1'b1 || dmem_addr !== (alu & ~32'h3) || mem_stall !== (k != ack_delay)) begin
                    errors++; $display("[TB] FAIL %s wait%0d: got req=%b addr=%h stall=%b want 1/%h/%b", name, k, dmem_req, dmem_addr, mem_stall, alu & ~32'h3, k != ack_delay);
                end
                @(posedge clk); #1;
            end
        end
        dmem_ack = 1'b0;
        checks++;
        if (PC_out !== pc || alures_out !== alu || imm_out !== imm || rd_out !== rd || WDSel_out !== wds) begin
            errors++; $display("[TB] FAIL %s fields: got pc=%h alu=%h rd=%0d want pc=%h alu=%h rd=%0d", name, PC_out, alures_out, rd_out, pc, alu, rd);
        end
        checks++;
        if (memdata_out !== exp_mem || RegWrite_out !== (rw && !mis) ||
            misalign_out !== mis || buserr_out !== 1'b0) begin
            errors++; $display("[TB] FAIL %s result: got mem=%h rw=%b mis=%b berr=%b want %h/%b/%b/0", name, memdata_out, RegWrite_out, misalign_out, buserr_out, exp_mem, rw && !mis, mis);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_instr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 ||
            {PC_out, alures_out, memdata_out, imm_out, rd_out, WDSel_out,
             RegWrite_out, misalign_out, buserr_out} !== '0) begin
            errors++; $display("[TB] FAIL reset_state: got req=%b stall=%b pc=%h want zeros", dmem_req, mem_stall, PC_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        apply_access("sw_word", 32'h40, 32'h100, 32'hDEADBEEF, 32'h4, 5'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        apply_access("lb_wait3", 32'h44, 32'h103, 32'h0, 32'h8, 5'd5, 3'd3, 2'd1, 1'b0, 1'b1, 1'b1, 32'h80FF_FF7F, 3);
        checks++;
        if (memdata_out !== 32'hFFFFFF80) begin
            errors++; $display("[TB] FAIL lb_value: got %h want ffffff80", memdata_out);
        end
        apply_access("sh_upper", 32'h48, 32'h102, 32'h1234ABCD, 32'h0, 5'd0, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1);
        apply_access("lhu_upper", 32'h4C, 32'h102, 32'h0, 32'h0, 5'd6, 3'd2, 2'd1, 1'b0, 1'b1, 1'b1, 32'hF00D0000, 2);
        checks++;
        if (memdata_out !== 32'h0000F00D) begin
            errors++; $display("[TB] FAIL lhu_value: got %h want 0000f00d", memdata_out);
        end
        apply_access("lw_misalign", 32'h50, 32'h101, 32'h0, 32'h0, 5'd7, 3'd0, 2'd1, 1'b0, 1'b1, 1'b1, 32'h0, 1);
        apply_access("add_after_mis", 32'h54, 32'h55, 32'h0, 32'h0, 5'd8, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1);
        apply_access("ld_st_both", 32'h58, 32'h201, 32'h000000A5, 32'h0, 5'd9, 3'd4, 2'd0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 0);
        apply_access("stray_ack", 32'h5C, 32'h77, 32'h0, 32'h0, 5'd10, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            apply_access("random", $urandom, $urandom, $urandom, $urandom,
                         5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                         2'($urandom_range(0, 3)), kind[1], kind[0], 1'($urandom_range(0, 1)),
                         $urandom, int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_timeout();
        int stalled;
        stalled = 0;
        drive_instr(32'h600, 32'h300, 32'h0, 32'h0, 5'd3, 3'd0, 2'd1, 1'b0, 1'b1, 1'b1);
        dmem_ack = 1'b0;
        #2;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_issue: got stall=%b want 1", mem_stall);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 300; c++) begin
            #2;
            if (!mem_stall) break;
            stalled++;
            @(posedge clk); #1;
        end
        checks++;
        if (stalled !== 255) begin
            errors++; $display("[TB] FAIL timeout_wait_cycles: got %0d want 255", stalled);
        end
        @(posedge clk); #1;
        checks++;
        if (buserr_out !== 1'b1 || RegWrite_out !== 1'b0 || PC_out !== 32'h600 || memdata_out !== 32'h0) begin
            errors++; $display("[TB] FAIL timeout_buserr: got berr=%b rw=%b pc=%h want 1/0/00000600", buserr_out, RegWrite_out, PC_out);
        end
        apply_access("after_timeout", 32'h604, 32'h304, 32'h0, 32'h0, 5'd4, 3'd0, 2'd1, 1'b0, 1'b1, 1'b1, 32'h12345678, 0);
    endtask

    task automatic test_reset_mid_wait();
        drive_instr(32'h700, 32'h400, 32'h0, 32'h0, 5'd2, 3'd0, 2'd1, 1'b0, 1'b1, 1'b1);
        dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 ||
            {PC_out, alures_out, memdata_out, imm_out, rd_out, WDSel_out,
             RegWrite_out, misalign_out, buserr_out} !== '0) begin
            errors++; $display("[TB] FAIL reset_mid_wait: got req=%b stall=%b pc=%h want zeros", dmem_req, mem_stall, PC_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply_access("add_after_rst", 32'h704, 32'h9, 32'h0, 32'h0, 5'd11, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0, 0);
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 PC_in, alures_in, rs2_data_in, imm_in  input  32 each  EX/MEM register outputs (PC, address/ALU result, store data, immediate).
REQ-004 rd_in  input  5;  DMType_in  input  3;  WDSel_in  input  2  EX/MEM register outputs.
REQ-005 MemWrite_in, load_in, RegWrite_in  input  1 each  EX/MEM control.
REQ-006 dmem_req, dmem_we  output  1 each  data-memory request strobe and write enable.
REQ-007 dmem_addr  output  32  word-aligned address, {alures_in[31:2],2'b00}.
REQ-008 dmem_wdata  output  32;  dmem_be  output  4  lane-replicated store data and byte enables.
REQ-009 dmem_ack  input  1;  dmem_rdata  input  32  memory completion and read word.
REQ-010 mem_stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-011 PC_out, alures_out, memdata_out, imm_out  output  32 each  MEM/WB register.
REQ-012 rd_out  output  5;  WDSel_out  output  2;  RegWrite_out, misalign_out, buserr_out  output  1 each  MEM/WB register.

Function
REQ-013 DMType encoding is fixed: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 are treated as word.
REQ-014 An access is valid when load_in or MemWrite_in is 1; if both are 1, the access is a store.
REQ-015 An access is misaligned when it is a word access with addr[1:0]!=0, or a halfword access with addr[0]=1.
REQ-016 Store be: word 1111; half 0011 shifted left by addr[1]*2; byte 0001 shifted left by addr[1:0].
REQ-017 Store wdata: word as-is; half {2{rs2[15:0]}}; byte {4{rs2[7:0]}}.
REQ-018 Load extraction selects the halfword by addr[1] or the byte by addr[1:0] from dmem_rdata, then sign- or zero-extends per DMType.
REQ-019 The FSM has two states, IDLE and WAIT.
  - IDLE: a valid, aligned access asserts dmem_req.
  - If dmem_ack is also 1 in that cycle, the access completes with no stall.
  - Otherwise mem_stall=1 and the FSM goes to WAIT.
REQ-020 In WAIT, dmem_req stays 1 with stable addr, we, be and wdata, and mem_stall=1 until dmem_ack.
  - On ack, mem_stall=0, the access completes and the FSM returns to IDLE.
REQ-021 An 8-bit wait counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches 255 without ack, the access aborts: the FSM returns to IDLE, mem_stall=0, and MEM/WB captures buserr_out=1 with RegWrite_out=0.
REQ-022 MEM/WB capture rules:
  - While mem_stall=1, it captures a bubble: all outputs 0.
  - Otherwise it captures the EX/MEM fields, with memdata_out equal to the extracted load data, or 0 for non-loads.
REQ-023 A misaligned access issues no dmem_req and no stall.
  - MEM/WB captures misalign_out=1 and RegWrite_out=0 for exactly one cycle.
REQ-024 Non-memory instructions pass through in one cycle, with dmem_req=0.
REQ-025 dmem_ack is ignored in IDLE when no request is issued.
REQ-026 Latency is 1 cycle to MEM/WB on a same-cycle ack, or N+1 cycles for an ack after N WAIT cycles.

Reset
REQ-027 rst asynchronously forces the FSM to IDLE, clears the counter, and zeros all MEM/WB outputs.
REQ-028 rst also forces dmem_req=0 and mem_stall=0, including when it arrives mid-WAIT.
  - A later stray ack is ignored.
REQ-029 The first access after reset release behaves as from IDLE.

Verification
REQ-030 Scenario: sw with alures=0x100, rs2=0xDEADBEEF, ack same cycle -> req=1, we=1, be=1111, wdata=0xDEADBEEF, no stall.
REQ-031 Scenario: lb with alures=0x103, rdata=0x80FF_FF7F, ack in 3rd WAIT cycle -> stall high 3 cycles, bubbles meanwhile, then memdata_out=0xFFFFFF80.
REQ-032 Scenario: sh with alures=0x102, rs2=0x1234ABCD -> be=1100, wdata=0xABCDABCD; lhu from 0x102 with rdata=0xF00D0000 -> memdata_out=0x0000F00D.
REQ-033 Scenario: lw with alures=0x101 -> no req, misalign_out=1 and RegWrite_out=0 for one cycle, no stall.
REQ-034 Scenario: load never acked -> stall for 255 WAIT cycles, then buserr_out=1, RegWrite_out=0, FSM IDLE.
REQ-035 Scenario: rst pulse during WAIT -> req and stall drop immediately, all outputs 0, next add instruction passes through with RegWrite_out=1.
